// File: rtl/dll_rx_dllp_decoder.sv
// dll_rx_dllp_decoder: two-stage DLLP receive path.
//   S1 captures DLLPs while the link is DL_Active.
//   S2 checks the CRC, decodes Ack/Nak and UpdateFC, and keeps the error count.
// Optional feature macro: DLLP_CRC_CHECK_EN. When it is not defined, every DLLP
// is treated as CRC-good and crc_err_o stays at 0.
module dll_rx_dllp_decoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           dlc_state_i,
  input  logic [47:0]          dllp_i,
  input  logic                 dllp_valid_i,
  output logic                 ack_valid_o,
  output logic                 nak_valid_o,
  output logic [11:0]          ack_nak_seq_o,
  output logic                 fc_update_o,
  output logic [1:0]           fc_type_o,
  output logic [7:0]           cl_hdr_p_o,
  output logic [7:0]           cl_hdr_np_o,
  output logic [7:0]           cl_hdr_cpl_o,
  output logic [11:0]          cl_data_p_o,
  output logic [11:0]          cl_data_np_o,
  output logic [11:0]          cl_data_cpl_o,
  output logic                 crc_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [1:0] DL_ACTIVE = 2'b11;
  localparam logic [4:0] TYPE_ACK_HI = 5'b00000;
  localparam logic [4:0] TYPE_NAK_HI = 5'b00010;
  localparam logic [4:0] FC_P_HI     = 5'b10000;
  localparam logic [4:0] FC_NP_HI    = 5'b10010;
  localparam logic [4:0] FC_CPL_HI   = 5'b10100;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

`ifdef DLLP_CRC_CHECK_EN
  // CRC-16 (poly 0x100B, seed 0xFFFF) over 32 bits, MSB first, result inverted.
  function automatic logic [15:0] crc16_dllp(input logic [31:0] data);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 31; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) begin
        c = c ^ 16'h100B;
      end else begin
        c = c;
      end
    end
    return ~c;
  endfunction
`endif

  // Pipeline and output state.
  logic                 s1_valid_q, s1_valid_d;
  logic [47:0]          s1_dllp_q, s1_dllp_d;
  logic [11:0]          last_ack_q, last_ack_d;
  logic                 ack_valid_q, ack_valid_d;
  logic                 nak_valid_q, nak_valid_d;
  logic [11:0]          seq_q, seq_d;
  logic                 fc_update_q, fc_update_d;
  logic [1:0]           fc_type_q, fc_type_d;
  logic [7:0]           hdr_p_q, hdr_p_d, hdr_np_q, hdr_np_d, hdr_cpl_q, hdr_cpl_d;
  logic [11:0]          data_p_q, data_p_d, data_np_q, data_np_d, data_cpl_q, data_cpl_d;
  logic                 crc_err_q, crc_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Decode helpers.
  logic                 active_s;
  logic                 crc_ok_s;
  logic [7:0]           type_s;
  logic [11:0]          seq_s;
  logic [11:0]          diff_s;
  logic                 in_window_s;
  logic                 err_inc_s;
  logic [7:0]           hdr_fc_s;
  logic [11:0]          data_fc_s;
  logic                 unused_s;

  assign active_s    = (dlc_state_i == DL_ACTIVE);
  assign type_s      = s1_dllp_q[47:40];
  assign seq_s       = s1_dllp_q[27:16];
  assign diff_s      = seq_s - last_ack_q;
  assign in_window_s = (diff_s != 12'h000) && (diff_s[11] == 1'b0);
  assign hdr_fc_s    = {s1_dllp_q[37:32], s1_dllp_q[31:30]};
  assign data_fc_s   = {s1_dllp_q[27:24], s1_dllp_q[23:16]};

`ifdef DLLP_CRC_CHECK_EN
  assign crc_ok_s = (crc16_dllp(s1_dllp_q[47:16]) == s1_dllp_q[15:0]);
  assign unused_s = ^{s1_dllp_q[39:38], s1_dllp_q[29:28]};
`else
  assign crc_ok_s = 1'b1;
  assign unused_s = ^{s1_dllp_q[39:38], s1_dllp_q[29:28], s1_dllp_q[15:0]};
`endif

  // S1 capture plus S2 check/decode: next-state for every flop.
  always_comb begin
    s1_valid_d  = dllp_valid_i & active_s;
    s1_dllp_d   = s1_dllp_q;
    last_ack_d  = last_ack_q;
    ack_valid_d = 1'b0;
    nak_valid_d = 1'b0;
    seq_d       = seq_q;
    fc_update_d = 1'b0;
    fc_type_d   = fc_type_q;
    hdr_p_d     = hdr_p_q;
    hdr_np_d    = hdr_np_q;
    hdr_cpl_d   = hdr_cpl_q;
    data_p_d    = data_p_q;
    data_np_d   = data_np_q;
    data_cpl_d  = data_cpl_q;
    crc_err_d   = 1'b0;
    err_inc_s   = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (dllp_valid_i && active_s) begin
      s1_dllp_d = dllp_i;
    end else begin
      s1_dllp_d = s1_dllp_q;
    end

    if (s1_valid_q && !crc_ok_s) begin
      crc_err_d = 1'b1;
      err_inc_s = 1'b1;
    end else if (s1_valid_q) begin
      case (type_s[7:3])
        TYPE_ACK_HI: begin
          if (type_s[2:0] != 3'b000) begin
            err_inc_s = 1'b1;
          end else if (in_window_s) begin
            ack_valid_d = 1'b1;
            seq_d       = seq_s;
            last_ack_d  = seq_s;
          end else if (diff_s[11]) begin
            err_inc_s = 1'b1;
          end else begin
            err_inc_s = 1'b0;
          end
        end
        TYPE_NAK_HI: begin
          if (type_s[2:0] != 3'b000) begin
            err_inc_s = 1'b1;
          end else begin
            nak_valid_d = 1'b1;
            seq_d       = seq_s;
            if (in_window_s) begin
              last_ack_d = seq_s;
            end else begin
              last_ack_d = last_ack_q;
            end
          end
        end
        FC_P_HI, FC_NP_HI, FC_CPL_HI: begin
          if (type_s[2:0] == 3'b000) begin
            fc_update_d = 1'b1;
            case (type_s[7:3])
              FC_P_HI: begin
                fc_type_d = 2'b00;
                hdr_p_d   = hdr_fc_s;
                data_p_d  = data_fc_s;
              end
              FC_NP_HI: begin
                fc_type_d = 2'b01;
                hdr_np_d  = hdr_fc_s;
                data_np_d = data_fc_s;
              end
              default: begin
                fc_type_d  = 2'b10;
                hdr_cpl_d  = hdr_fc_s;
                data_cpl_d = data_fc_s;
              end
            endcase
          end else begin
            fc_update_d = 1'b0;
          end
        end
        default: begin
          err_inc_s = 1'b1;
        end
      endcase
    end else begin
      err_inc_s = 1'b0;
    end

    // Leaving DL_Active restarts the Ack window regardless of S2 traffic.
    if (!active_s) begin
      last_ack_d = 12'hFFF;
    end else begin
      last_ack_d = last_ack_d;
    end

    if (err_inc_s && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_ONE;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_dllp_q   <= 48'h0;
      last_ack_q  <= 12'hFFF;
      ack_valid_q <= 1'b0;
      nak_valid_q <= 1'b0;
      seq_q       <= 12'h000;
      fc_update_q <= 1'b0;
      fc_type_q   <= 2'b00;
      hdr_p_q     <= 8'h00;
      hdr_np_q    <= 8'h00;
      hdr_cpl_q   <= 8'h00;
      data_p_q    <= 12'h000;
      data_np_q   <= 12'h000;
      data_cpl_q  <= 12'h000;
      crc_err_q   <= 1'b0;
      err_cnt_q   <= {ERR_CNT_W{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_dllp_q   <= s1_dllp_d;
      last_ack_q  <= last_ack_d;
      ack_valid_q <= ack_valid_d;
      nak_valid_q <= nak_valid_d;
      seq_q       <= seq_d;
      fc_update_q <= fc_update_d;
      fc_type_q   <= fc_type_d;
      hdr_p_q     <= hdr_p_d;
      hdr_np_q    <= hdr_np_d;
      hdr_cpl_q   <= hdr_cpl_d;
      data_p_q    <= data_p_d;
      data_np_q   <= data_np_d;
      data_cpl_q  <= data_cpl_d;
      crc_err_q   <= crc_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign ack_valid_o   = ack_valid_q;
  assign nak_valid_o   = nak_valid_q;
  assign ack_nak_seq_o = seq_q;
  assign fc_update_o   = fc_update_q;
  assign fc_type_o     = fc_type_q;
  assign cl_hdr_p_o    = hdr_p_q;
  assign cl_hdr_np_o   = hdr_np_q;
  assign cl_hdr_cpl_o  = hdr_cpl_q;
  assign cl_data_p_o   = data_p_q;
  assign cl_data_np_o  = data_np_q;
  assign cl_data_cpl_o = data_cpl_q;
  assign crc_err_o     = crc_err_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_dll_rx_dllp_decoder.sv
// Directed bench for dll_rx_dllp_decoder. Expectations for DLLP_CRC_CHECK_EN
// builds are selected with the same macro.
module tb_dll_rx_dllp_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dlc_state_i;
  logic [47:0] dllp_i;
  logic        dllp_valid_i;
  logic        ack_valid_o, nak_valid_o, fc_update_o, crc_err_o;
  logic [11:0] ack_nak_seq_o;
  logic [1:0]  fc_type_o;
  logic [7:0]  cl_hdr_p_o, cl_hdr_np_o, cl_hdr_cpl_o;
  logic [11:0] cl_data_p_o, cl_data_np_o, cl_data_cpl_o;
  logic [7:0]  err_cnt_o;

  int vectors = 0;
  int miscompares = 0;
  int exp_err = 0;

  dll_rx_dllp_decoder #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .dlc_state_i(dlc_state_i), .dllp_i(dllp_i),
    .dllp_valid_i(dllp_valid_i), .ack_valid_o(ack_valid_o), .nak_valid_o(nak_valid_o),
    .ack_nak_seq_o(ack_nak_seq_o), .fc_update_o(fc_update_o), .fc_type_o(fc_type_o),
    .cl_hdr_p_o(cl_hdr_p_o), .cl_hdr_np_o(cl_hdr_np_o), .cl_hdr_cpl_o(cl_hdr_cpl_o),
    .cl_data_p_o(cl_data_p_o), .cl_data_np_o(cl_data_np_o), .cl_data_cpl_o(cl_data_cpl_o),
    .crc_err_o(crc_err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC-16, poly 0x100B, seed 0xFFFF, bit 47 first, inverted.
  function automatic logic [15:0] crc16(input logic [31:0] msg);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int i = 31; i >= 0; i--) begin
      if (r[15] ^ msg[i]) r = {r[14:0], 1'b0} ^ 16'h100B;
      else                r = {r[14:0], 1'b0};
    end
    return ~r;
  endfunction

  function automatic logic [47:0] mk(input logic [7:0] t, input logic [23:0] body);
    return {t, body, crc16({t, body})};
  endfunction

  function automatic logic [47:0] ack(input logic [11:0] s);
    return mk(8'h00, {12'h000, s});
  endfunction

  function automatic logic [47:0] nak(input logic [11:0] s);
    return mk(8'h10, {12'h000, s});
  endfunction

  function automatic logic [47:0] fc(input logic [7:0] t, input logic [7:0] h, input logic [11:0] d);
    return mk(t, {2'b00, h, 2'b00, d});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dllp_valid_i = 1'b0;
    dllp_i       = 48'h0;
  endtask

  // Drive one DLLP for a cycle, then wait until its result is visible.
  task automatic send(input logic [47:0] d);
    dllp_i       = d;
    dllp_valid_i = 1'b1;
    step();
    idle();
    step();
  endtask

  task automatic expect_ack(input string tag, input logic exp_v, input logic [11:0] exp_s);
    chk({tag, "_ack"}, {31'd0, ack_valid_o}, {31'd0, exp_v});
    if (exp_v) chk({tag, "_seq"}, {20'd0, ack_nak_seq_o}, {20'd0, exp_s});
    else       chk({tag, "_err"}, {24'd0, err_cnt_o}, exp_err);
  endtask

  initial begin
    rst = 1'b1;
    dlc_state_i = 2'b11;
    idle();
    step();
    step();
    chk("rst_ack", {31'd0, ack_valid_o}, 32'd0);
    chk("rst_err", {24'd0, err_cnt_o}, 32'd0);
    chk("rst_hdr_np", {24'd0, cl_hdr_np_o}, 32'd0);
    chk("rst_data_cpl", {20'd0, cl_data_cpl_o}, 32'd0);

    // DLLP offered in the reset cycle must vanish.
    dllp_i = ack(12'h000);
    dllp_valid_i = 1'b1;
    step();
    rst = 1'b0;
    idle();
    step();
    chk("rst_discard", {31'd0, ack_valid_o}, 32'd0);

    // last_ack starts at FFF: seq 000 is diff 1.
    send(ack(12'h000));
    expect_ack("ack000", 1'b1, 12'h000);
    send(ack(12'h000));
    expect_ack("dup000", 1'b0, 12'h000);

    // Window edges: diff 2046, diff 2047 accepted; diff 2048 stale.
    send(ack(12'h7FE));
    expect_ack("ack7fe", 1'b1, 12'h7FE);
    send(ack(12'hFFD));
    expect_ack("ackffd", 1'b1, 12'hFFD);
    send(ack(12'h7FD));
    exp_err = 1;
    expect_ack("stale7fd", 1'b0, 12'h000);
    send(ack(12'h010));
    expect_ack("ack010", 1'b1, 12'h010);
    send(ack(12'h810));
    exp_err = 2;
    expect_ack("stale810", 1'b0, 12'h000);

    // Nak always pulses; only an in-window Nak moves last_ack.
    send(nak(12'h020));
    chk("nak020_v", {31'd0, nak_valid_o}, 32'd1);
    chk("nak020_seq", {20'd0, ack_nak_seq_o}, 32'h020);
    send(ack(12'h020));
    expect_ack("dup020", 1'b0, 12'h000);
    send(nak(12'h005));
    chk("nak005_v", {31'd0, nak_valid_o}, 32'd1);
    chk("nak005_seq", {20'd0, ack_nak_seq_o}, 32'h005);
    chk("nak005_err", {24'd0, err_cnt_o}, exp_err);
    send(ack(12'h005));
    exp_err = 3;
    expect_ack("stale005", 1'b0, 12'h000);

    // UpdateFC for each type, then a VC1 update that must be ignored.
    send(fc(8'h90, 8'h20, 12'h0C0));
    chk("fcnp_upd", {31'd0, fc_update_o}, 32'd1);
    chk("fcnp_type", {30'd0, fc_type_o}, 32'd1);
    chk("fcnp_hdr", {24'd0, cl_hdr_np_o}, 32'h20);
    chk("fcnp_data", {20'd0, cl_data_np_o}, 32'h0C0);
    chk("fcnp_hdr_p", {24'd0, cl_hdr_p_o}, 32'h00);
    chk("fcnp_data_cpl", {20'd0, cl_data_cpl_o}, 32'h000);
    send(fc(8'h91, 8'h33, 12'h111));
    chk("fcvc1_upd", {31'd0, fc_update_o}, 32'd0);
    chk("fcvc1_hdr", {24'd0, cl_hdr_np_o}, 32'h20);
    chk("fcvc1_data", {20'd0, cl_data_np_o}, 32'h0C0);
    send(fc(8'hA0, 8'h44, 12'h123));
    chk("fccpl_type", {30'd0, fc_type_o}, 32'd2);
    chk("fccpl_hdr", {24'd0, cl_hdr_cpl_o}, 32'h44);
    chk("fccpl_data", {20'd0, cl_data_cpl_o}, 32'h123);
    chk("fccpl_err", {24'd0, err_cnt_o}, exp_err);

    // Corrupted CRC on an otherwise in-window Ack (last_ack = 020).
    send(ack(12'h021) ^ 48'h1);
`ifdef DLLP_CRC_CHECK_EN
    exp_err = 4;
    chk("crcbad_err_pulse", {31'd0, crc_err_o}, 32'd1);
    expect_ack("crcbad", 1'b0, 12'h000);
`else
    chk("crcbad_err_pulse", {31'd0, crc_err_o}, 32'd0);
    expect_ack("crcbad", 1'b1, 12'h021);
`endif

    // Back-to-back: Ack, UpdateFC-P, then Nak while leaving DL_Active.
    dllp_i = ack(12'h100);
    dllp_valid_i = 1'b1;
    step();
    dllp_i = fc(8'h80, 8'h55, 12'h0AA);
    step();
    chk("b2b_ack", {31'd0, ack_valid_o}, 32'd1);
    chk("b2b_ack_seq", {20'd0, ack_nak_seq_o}, 32'h100);
    dllp_i = nak(12'h200);
    dlc_state_i = 2'b01;
    step();
    chk("b2b_fc", {31'd0, fc_update_o}, 32'd1);
    chk("b2b_fc_type", {30'd0, fc_type_o}, 32'd0);
    chk("b2b_hdr_p", {24'd0, cl_hdr_p_o}, 32'h55);
    chk("b2b_data_p", {20'd0, cl_data_p_o}, 32'h0AA);
    idle();
    step();
    chk("b2b_nak_drop", {31'd0, nak_valid_o}, 32'd0);
    chk("b2b_hold_hdr_np", {24'd0, cl_hdr_np_o}, 32'h20);
    dlc_state_i = 2'b11;
    send(ack(12'h000));
    expect_ack("reentry000", 1'b1, 12'h000);

    // 300 unknown-type DLLPs saturate the counter.
    dllp_valid_i = 1'b1;
    dllp_i = mk(8'h31, 24'h000000);
    for (int i = 0; i < 300; i++) step();
    idle();
    step();
    step();
    chk("sat_err", {24'd0, err_cnt_o}, 32'hFF);

    // Reset mid-stream: outputs clear the next cycle, in-flight DLLPs dropped.
    dllp_i = ack(12'h001);
    dllp_valid_i = 1'b1;
    step();
    dllp_i = ack(12'h002);
    rst = 1'b1;
    step();
    chk("mid_rst_ack", {31'd0, ack_valid_o}, 32'd0);
    chk("mid_rst_err", {24'd0, err_cnt_o}, 32'd0);
    chk("mid_rst_hdr_p", {24'd0, cl_hdr_p_o}, 32'd0);
    chk("mid_rst_hdr_np", {24'd0, cl_hdr_np_o}, 32'd0);
    rst = 1'b0;
    idle();
    step();
    chk("mid_rst_discard", {31'd0, ack_valid_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
